// File: rtl/yutorina_ex_stage_md.sv
// Execute stage: single-cycle ALU plus an iterative unsigned mul/div unit with EX/MEM latch and forwarding.
// Define YUTORINA_EX_MD_EN to build the mul/div unit; otherwise md ops are latched with EXP_UNDEF.
module yutorina_ex_stage_md #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned ALUOP_W   = 4,
   parameter int unsigned MEMOP_W   = 2,
   parameter int unsigned CTRLOP_W  = 2,
   parameter int unsigned EXP_W     = 3,
   parameter logic [EXP_W-1:0] EXP_UNDEF = EXP_W'(1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                flush,
   input  logic                id_en_,
   input  logic [ALUOP_W-1:0]  id_alu_op,
   input  logic [DATA_W-1:0]   id_alu_lhs,
   input  logic [DATA_W-1:0]   id_alu_rhs,
   input  logic [1:0]          id_md_op,
   input  logic [ADDR_W-1:0]   id_w_addr,
   input  logic [DATA_W-1:0]   id_w_data,
   input  logic                id_gpr_we_,
   input  logic [EXP_W-1:0]    id_exp_code,
   input  logic [MEMOP_W-1:0]  id_mem_op,
   input  logic [CTRLOP_W-1:0] id_ctrl_op,
   output logic                ex_en_,
   output logic                ex_gpr_we_,
   output logic [ADDR_W-1:0]   ex_w_addr,
   output logic [DATA_W-1:0]   ex_w_data,
   output logic [DATA_W-1:0]   ex_out,
   output logic [EXP_W-1:0]    ex_exp_code,
   output logic [MEMOP_W-1:0]  ex_mem_op,
   output logic [CTRLOP_W-1:0] ex_ctrl_op,
   output logic                ex_busy,
   output logic [ADDR_W-1:0]   fwd_addr,
   output logic [DATA_W-1:0]   fwd_out,
   output logic                fwd_valid_
);
   localparam int unsigned SHAMT_W = $clog2(DATA_W);
   localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(0);
   localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(1);
   localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(2);
   localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(3);
   localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(4);
   localparam logic [ALUOP_W-1:0] ALU_SLL  = ALUOP_W'(5);
   localparam logic [ALUOP_W-1:0] ALU_SRL  = ALUOP_W'(6);
   localparam logic [ALUOP_W-1:0] ALU_SRA  = ALUOP_W'(7);
   localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(8);
   localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(9);

   logic [DATA_W-1:0]  alu_res;
   logic [SHAMT_W-1:0] shamt;
   logic               md_req;
   logic               idle;

   assign shamt  = id_alu_rhs[SHAMT_W-1:0];
   assign md_req = (id_md_op != 2'd0);

   // Single-cycle ALU, also the forwarding source
   always_comb begin
      alu_res = '0;
      case (id_alu_op)
         ALU_ADD:  alu_res = id_alu_lhs + id_alu_rhs;
         ALU_SUB:  alu_res = id_alu_lhs - id_alu_rhs;
         ALU_AND:  alu_res = id_alu_lhs & id_alu_rhs;
         ALU_OR:   alu_res = id_alu_lhs | id_alu_rhs;
         ALU_XOR:  alu_res = id_alu_lhs ^ id_alu_rhs;
         ALU_SLL:  alu_res = id_alu_lhs << shamt;
         ALU_SRL:  alu_res = id_alu_lhs >> shamt;
         ALU_SRA:  alu_res = DATA_W'($signed(id_alu_lhs) >>> shamt);
         ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(id_alu_lhs) < $signed(id_alu_rhs)};
         ALU_SLTU: alu_res = {{(DATA_W-1){1'b0}}, id_alu_lhs < id_alu_rhs};
         default:  alu_res = '0;
      endcase
   end

   assign fwd_addr   = id_w_addr;
   assign fwd_out    = alu_res;
   assign fwd_valid_ = ~idle | id_en_ | id_gpr_we_ | md_req;

`ifdef YUTORINA_EX_MD_EN
   localparam int unsigned CNT_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t              state, state_next;
   logic                accept_alu, accept_md, md_step, md_finish;
   logic [CNT_W-1:0]    cnt;
   logic [1:0]          md_sel;
   logic [DATA_W-1:0]   acc, opa, opb, md_res;
   logic [DATA_W:0]     rem_shift, rem_diff;
   logic                rem_ge;
   logic [ADDR_W-1:0]   sh_w_addr;
   logic [DATA_W-1:0]   sh_w_data;
   logic                sh_gpr_we_;
   logic [EXP_W-1:0]    sh_exp_code;
   logic [MEMOP_W-1:0]  sh_mem_op;
   logic [CTRLOP_W-1:0] sh_ctrl_op;

   assign idle    = (state == S_IDLE);
   assign ex_busy = ~idle;

   always_ff @(posedge clk) begin
      if (rst)         state <= S_IDLE;
      else if (flush)  state <= S_IDLE;
      else if (!stall) state <= state_next;
   end

   always_comb begin
      state_next = state;
      accept_alu = 1'b0;
      accept_md  = 1'b0;
      md_step    = 1'b0;
      md_finish  = 1'b0;
      case (state)
         S_IDLE: begin
            if (!id_en_) begin
               if (md_req) begin
                  accept_md  = 1'b1;
                  state_next = S_BUSY;
               end else begin
                  accept_alu = 1'b1;
               end
            end
         end
         S_BUSY: begin
            md_step = 1'b1;
            if (cnt == CNT_W'(1)) state_next = S_DONE;
         end
         S_DONE: begin
            md_finish  = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Restoring divide step; a zero divisor naturally yields all-ones quotient and remainder = lhs
   assign rem_shift = {acc, opa[DATA_W-1]};
   assign rem_ge    = (rem_shift >= {1'b0, opb});
   assign rem_diff  = rem_shift - {1'b0, opb};

   always_comb begin
      md_res = acc;
      if (md_sel == 2'd2) md_res = opa;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_en_      <= 1'b1;
         ex_gpr_we_  <= 1'b1;
         ex_w_addr   <= '0;
         ex_w_data   <= '0;
         ex_out      <= '0;
         ex_exp_code <= '0;
         ex_mem_op   <= '0;
         ex_ctrl_op  <= '0;
         cnt         <= '0;
         md_sel      <= '0;
         acc         <= '0;
         opa         <= '0;
         opb         <= '0;
         sh_w_addr   <= '0;
         sh_w_data   <= '0;
         sh_gpr_we_  <= 1'b1;
         sh_exp_code <= '0;
         sh_mem_op   <= '0;
         sh_ctrl_op  <= '0;
      end else if (flush) begin
         ex_en_     <= 1'b1;
         ex_gpr_we_ <= 1'b1;
      end else if (!stall) begin
         if (accept_alu) begin
            ex_en_      <= 1'b0;
            ex_gpr_we_  <= id_gpr_we_;
            ex_w_addr   <= id_w_addr;
            ex_w_data   <= id_w_data;
            ex_out      <= alu_res;
            ex_exp_code <= id_exp_code;
            ex_mem_op   <= id_mem_op;
            ex_ctrl_op  <= id_ctrl_op;
         end else if (accept_md) begin
            ex_en_      <= 1'b1;
            cnt         <= CNT_W'(DATA_W);
            md_sel      <= id_md_op;
            acc         <= '0;
            opa         <= id_alu_lhs;
            opb         <= id_alu_rhs;
            sh_w_addr   <= id_w_addr;
            sh_w_data   <= id_w_data;
            sh_gpr_we_  <= id_gpr_we_;
            sh_exp_code <= id_exp_code;
            sh_mem_op   <= id_mem_op;
            sh_ctrl_op  <= id_ctrl_op;
         end else if (md_step) begin
            cnt <= cnt - CNT_W'(1);
            if (md_sel == 2'd1) begin
               acc <= opb[0] ? (acc + opa) : acc;
               opa <= opa << 1;
               opb <= opb >> 1;
            end else begin
               acc <= rem_ge ? rem_diff[DATA_W-1:0] : rem_shift[DATA_W-1:0];
               opa <= {opa[DATA_W-2:0], rem_ge};
            end
         end else if (md_finish) begin
            ex_en_      <= 1'b0;
            ex_out      <= md_res;
            ex_gpr_we_  <= sh_gpr_we_;
            ex_w_addr   <= sh_w_addr;
            ex_w_data   <= sh_w_data;
            ex_exp_code <= sh_exp_code;
            ex_mem_op   <= sh_mem_op;
            ex_ctrl_op  <= sh_ctrl_op;
         end else begin
            ex_en_ <= 1'b1;
         end
      end
   end
`else
   assign idle    = 1'b1;
   assign ex_busy = 1'b0;

   // md ops are unsupported here: latch them as a non-writing exception
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_en_      <= 1'b1;
         ex_gpr_we_  <= 1'b1;
         ex_w_addr   <= '0;
         ex_w_data   <= '0;
         ex_out      <= '0;
         ex_exp_code <= '0;
         ex_mem_op   <= '0;
         ex_ctrl_op  <= '0;
      end else if (flush) begin
         ex_en_     <= 1'b1;
         ex_gpr_we_ <= 1'b1;
      end else if (!stall) begin
         if (!id_en_) begin
            ex_en_      <= 1'b0;
            ex_w_addr   <= id_w_addr;
            ex_w_data   <= id_w_data;
            ex_mem_op   <= id_mem_op;
            ex_ctrl_op  <= id_ctrl_op;
            ex_gpr_we_  <= md_req ? 1'b1 : id_gpr_we_;
            ex_exp_code <= md_req ? EXP_UNDEF : id_exp_code;
            ex_out      <= md_req ? '0 : alu_res;
         end else begin
            ex_en_ <= 1'b1;
         end
      end
   end
`endif
endmodule

// File: tb/tb_yutorina_ex_stage_md.sv
// Directed self-checking bench for yutorina_ex_stage_md (mul/div tests need YUTORINA_EX_MD_EN).
module tb_yutorina_ex_stage_md;
   logic        clk, rst, stall, flush, id_en_;
   logic [3:0]  id_alu_op;
   logic [31:0] id_alu_lhs, id_alu_rhs, id_w_data;
   logic [1:0]  id_md_op;
   logic [4:0]  id_w_addr;
   logic        id_gpr_we_;
   logic [2:0]  id_exp_code;
   logic [1:0]  id_mem_op, id_ctrl_op;
   logic        ex_en_, ex_gpr_we_, ex_busy, fwd_valid_;
   logic [4:0]  ex_w_addr, fwd_addr;
   logic [31:0] ex_w_data, ex_out, fwd_out;
   logic [2:0]  ex_exp_code;
   logic [1:0]  ex_mem_op, ex_ctrl_op;

   int n_pass  = 0;
   int n_total = 0;

   yutorina_ex_stage_md #(
      .DATA_W(32), .ADDR_W(5), .ALUOP_W(4), .MEMOP_W(2), .CTRLOP_W(2), .EXP_W(3), .EXP_UNDEF(3'd1)
   ) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_en_(id_en_),
      .id_alu_op(id_alu_op), .id_alu_lhs(id_alu_lhs), .id_alu_rhs(id_alu_rhs),
      .id_md_op(id_md_op), .id_w_addr(id_w_addr), .id_w_data(id_w_data),
      .id_gpr_we_(id_gpr_we_), .id_exp_code(id_exp_code), .id_mem_op(id_mem_op),
      .id_ctrl_op(id_ctrl_op), .ex_en_(ex_en_), .ex_gpr_we_(ex_gpr_we_),
      .ex_w_addr(ex_w_addr), .ex_w_data(ex_w_data), .ex_out(ex_out),
      .ex_exp_code(ex_exp_code), .ex_mem_op(ex_mem_op), .ex_ctrl_op(ex_ctrl_op),
      .ex_busy(ex_busy), .fwd_addr(fwd_addr), .fwd_out(fwd_out), .fwd_valid_(fwd_valid_)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] l, input logic [31:0] r,
                        input logic [1:0] md, input logic [4:0] wa, input logic we_);
      id_en_      = 1'b0;
      id_alu_op   = op;
      id_alu_lhs  = l;
      id_alu_rhs  = r;
      id_md_op    = md;
      id_w_addr   = wa;
      id_w_data   = 32'h100 + 32'(wa);
      id_gpr_we_  = we_;
      id_exp_code = 3'd0;
      id_mem_op   = 2'd1;
      id_ctrl_op  = 2'd2;
   endtask

`ifdef YUTORINA_EX_MD_EN
   // Issues an md op, queues ADD 1+1 behind it in ID, optionally stalls mid-BUSY
   task automatic run_md(input string tag, input logic [1:0] md, input logic [31:0] l,
                         input logic [31:0] r, input logic [31:0] exp,
                         input int stall_at, input int stall_len);
      int busy_cnt = 0;
      logic bad_bubble = 1'b0;
      logic bad_hold = 1'b0;
      logic [31:0] held;
      issue(4'd0, l, r, md, 5'd9, 1'b0);
      #1;
      check({tag, " fwd_valid_ md"}, 64'(fwd_valid_), 64'd1);
      tick();
      issue(4'd0, 32'd1, 32'd1, 2'd0, 5'd4, 1'b0);
      for (int i = 0; i < 200 && ex_busy === 1'b1; i++) begin
         busy_cnt++;
         if (ex_en_ !== 1'b1 || fwd_valid_ !== 1'b1) bad_bubble = 1'b1;
         if (busy_cnt == stall_at) begin
            stall = 1'b1;
            held  = ex_out;
            for (int s = 0; s < stall_len; s++) begin
               tick();
               if (ex_busy === 1'b1) busy_cnt++;
               if (ex_busy !== 1'b1 || ex_out !== held || ex_en_ !== 1'b1) bad_hold = 1'b1;
            end
            stall = 1'b0;
         end
         tick();
      end
      check({tag, " busy cycles"}, 64'(busy_cnt), 64'(33 + stall_len));
      check({tag, " bubble"}, 64'(bad_bubble), 64'd0);
      if (stall_len > 0) check({tag, " stall hold"}, 64'(bad_hold), 64'd0);
      check({tag, " ex_en_"}, 64'(ex_en_), 64'd0);
      check({tag, " ex_out"}, 64'(ex_out), 64'(exp));
      check({tag, " ex_w_addr"}, 64'(ex_w_addr), 64'd9);
      check({tag, " ex_w_data"}, 64'(ex_w_data), 64'h109);
      tick();
      id_en_ = 1'b1;
      check({tag, " next add"}, 64'(ex_out), 64'd2);
   endtask
`endif

   logic [3:0]  t_op  [10];
   logic [31:0] t_lhs [10];
   logic [31:0] t_rhs [10];
   logic [31:0] t_exp [10];

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      issue(4'd0, 32'd0, 32'd0, 2'd0, 5'd0, 1'b1);
      id_en_ = 1'b1;
      tick(); tick();
      rst = 1'b0;
      check("rst ex_en_", 64'(ex_en_), 64'd1);
      check("rst ex_gpr_we_", 64'(ex_gpr_we_), 64'd1);
      check("rst ex_out", 64'(ex_out), 64'd0);
      check("rst ex_w_addr", 64'(ex_w_addr), 64'd0);
      check("rst ex_busy", 64'(ex_busy), 64'd0);

      // ADD 5+7 with same-cycle forwarding
      issue(4'd0, 32'd5, 32'd7, 2'd0, 5'd3, 1'b0);
      #1;
      check("add fwd_out", 64'(fwd_out), 64'd12);
      check("add fwd_valid_", 64'(fwd_valid_), 64'd0);
      check("add fwd_addr", 64'(fwd_addr), 64'd3);
      tick();
      check("add ex_out", 64'(ex_out), 64'd12);
      check("add ex_en_", 64'(ex_en_), 64'd0);
      check("add ex_w_addr", 64'(ex_w_addr), 64'd3);
      check("add ex_gpr_we_", 64'(ex_gpr_we_), 64'd0);
      check("add ex_w_data", 64'(ex_w_data), 64'h103);
      check("add ex_mem_op", 64'(ex_mem_op), 64'd1);
      check("add ex_ctrl_op", 64'(ex_ctrl_op), 64'd2);

      t_op[0] = 4'd1; t_lhs[0] = 32'd5;         t_rhs[0] = 32'd7;         t_exp[0] = 32'hFFFF_FFFE;
      t_op[1] = 4'd2; t_lhs[1] = 32'hF0F0_F0F0; t_rhs[1] = 32'hFF00_FF00; t_exp[1] = 32'hF000_F000;
      t_op[2] = 4'd3; t_lhs[2] = 32'hF0F0_F0F0; t_rhs[2] = 32'h0F0F_0000; t_exp[2] = 32'hFFFF_F0F0;
      t_op[3] = 4'd4; t_lhs[3] = 32'hFFFF_0000; t_rhs[3] = 32'h0F0F_0F0F; t_exp[3] = 32'hF0F0_0F0F;
      t_op[4] = 4'd5; t_lhs[4] = 32'd1;         t_rhs[4] = 32'h24;        t_exp[4] = 32'h10;
      t_op[5] = 4'd6; t_lhs[5] = 32'h8000_0000; t_rhs[5] = 32'd4;         t_exp[5] = 32'h0800_0000;
      t_op[6] = 4'd7; t_lhs[6] = 32'h8000_0000; t_rhs[6] = 32'd4;         t_exp[6] = 32'hF800_0000;
      t_op[7] = 4'd8; t_lhs[7] = 32'hFFFF_FFFF; t_rhs[7] = 32'd5;         t_exp[7] = 32'd1;
      t_op[8] = 4'd9; t_lhs[8] = 32'hFFFF_FFFF; t_rhs[8] = 32'd5;         t_exp[8] = 32'd0;
      t_op[9] = 4'd0; t_lhs[9] = 32'hFFFF_FFFF; t_rhs[9] = 32'd1;         t_exp[9] = 32'd0;
      for (int i = 0; i < 10; i++) begin
         issue(t_op[i], t_lhs[i], t_rhs[i], 2'd0, 5'(i + 10), 1'b0);
         #1;
         check($sformatf("alu%0d fwd_out", i), 64'(fwd_out), 64'(t_exp[i]));
         tick();
         check($sformatf("alu%0d ex_out", i), 64'(ex_out), 64'(t_exp[i]));
         check($sformatf("alu%0d ex_w_addr", i), 64'(ex_w_addr), 64'(i + 10));
      end

      // No instruction: bubble, data held; gpr_we_=1 gives no forward
      issue(4'd0, 32'd3, 32'd4, 2'd0, 5'd6, 1'b1);
      #1;
      check("nowrite fwd_valid_", 64'(fwd_valid_), 64'd1);
      id_en_ = 1'b1;
      tick();
      check("idle ex_en_", 64'(ex_en_), 64'd1);
      check("idle ex_out hold", 64'(ex_out), 64'd0);

      // Stall holds outputs, then the instruction completes
      issue(4'd0, 32'd1, 32'd2, 2'd0, 5'd7, 1'b0);
      stall = 1'b1;
      tick();
      check("stall ex_en_", 64'(ex_en_), 64'd1);
      check("stall ex_out", 64'(ex_out), 64'd0);
      stall = 1'b0;
      tick();
      check("post-stall ex_out", 64'(ex_out), 64'd3);
      check("post-stall ex_en_", 64'(ex_en_), 64'd0);

      // Flush beats stall and kills the latch
      issue(4'd0, 32'd8, 32'd8, 2'd0, 5'd8, 1'b0);
      flush = 1'b1; stall = 1'b1;
      tick();
      flush = 1'b0; stall = 1'b0; id_en_ = 1'b1;
      check("flush ex_en_", 64'(ex_en_), 64'd1);
      check("flush ex_gpr_we_", 64'(ex_gpr_we_), 64'd1);
      check("flush ex_out hold", 64'(ex_out), 64'd3);

`ifdef YUTORINA_EX_MD_EN
      run_md("mul", 2'd1, 32'h0001_0003, 32'd5, 32'h0005_000F, 0, 0);
      run_md("mul ones", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 0, 0);
      run_md("divu", 2'd2, 32'd100, 32'd7, 32'd14, 0, 0);
      run_md("remu", 2'd3, 32'd100, 32'd7, 32'd2, 0, 0);
      run_md("divu0", 2'd2, 32'd9, 32'd0, 32'hFFFF_FFFF, 0, 0);
      run_md("remu0", 2'd3, 32'd9, 32'd0, 32'd9, 0, 0);
      run_md("divu big", 2'd2, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 0, 0);
      run_md("mul stall", 2'd1, 32'h0001_0003, 32'd5, 32'h0005_000F, 10, 5);

      begin : flush_busy
         logic pulse = 1'b0;
         issue(4'd0, 32'd6, 32'd6, 2'd1, 5'd5, 1'b0);
         tick();
         id_en_ = 1'b1;
         for (int i = 0; i < 9; i++) tick();
         check("flush busy pre", 64'(ex_busy), 64'd1);
         flush = 1'b1;
         tick();
         flush = 1'b0;
         check("flush busy", 64'(ex_busy), 64'd0);
         for (int i = 0; i < 40; i++) begin
            if (ex_en_ !== 1'b1) pulse = 1'b1;
            tick();
         end
         check("flush no pulse", 64'(pulse), 64'd0);
         issue(4'd0, 32'd1, 32'd1, 2'd0, 5'd2, 1'b0);
         tick();
         id_en_ = 1'b1;
         check("flush then add", 64'(ex_out), 64'd2);
         check("flush then add en", 64'(ex_en_), 64'd0);
      end

      begin : rst_busy
         logic pulse = 1'b0;
         issue(4'd0, 32'd6, 32'd6, 2'd1, 5'd5, 1'b0);
         tick();
         id_en_ = 1'b1;
         for (int i = 0; i < 5; i++) tick();
         rst = 1'b1;
         tick();
         rst = 1'b0;
         check("rst busy ex_busy", 64'(ex_busy), 64'd0);
         check("rst busy ex_en_", 64'(ex_en_), 64'd1);
         check("rst busy ex_gpr_we_", 64'(ex_gpr_we_), 64'd1);
         check("rst busy ex_out", 64'(ex_out), 64'd0);
         check("rst busy ex_w_addr", 64'(ex_w_addr), 64'd0);
         check("rst busy ex_w_data", 64'(ex_w_data), 64'd0);
         for (int i = 0; i < 40; i++) begin
            if (ex_en_ !== 1'b1 || ex_busy !== 1'b0) pulse = 1'b1;
            tick();
         end
         check("rst busy no result", 64'(pulse), 64'd0);
      end
`else
      // md op without the unit: one-cycle latch with an undefined-op exception
      issue(4'd0, 32'h0001_0003, 32'd5, 2'd1, 5'd11, 1'b0);
      #1;
      check("undef fwd_valid_", 64'(fwd_valid_), 64'd1);
      check("undef busy pre", 64'(ex_busy), 64'd0);
      tick();
      id_en_ = 1'b1;
      check("undef ex_exp_code", 64'(ex_exp_code), 64'd1);
      check("undef ex_gpr_we_", 64'(ex_gpr_we_), 64'd1);
      check("undef ex_out", 64'(ex_out), 64'd0);
      check("undef ex_en_", 64'(ex_en_), 64'd0);
      check("undef ex_w_addr", 64'(ex_w_addr), 64'd11);
      check("undef ex_busy", 64'(ex_busy), 64'd0);
      tick();
      check("undef after ex_en_", 64'(ex_en_), 64'd1);
      check("undef after ex_busy", 64'(ex_busy), 64'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
